mmio_bus_fabric: RTL and testbench
==================================

Name: mmio_bus_fabric

Overview:
- Parametrised successor to the flat memory/IO decoder: one CPU-side request/ready port fanned out to one RAM slot and NUM_IO peripheral slots.
- Each peripheral slot has 2^REG_BITS registers.
- Adds per-access wait states via device ready, a registered read-data return, a bus-error response for unmapped addresses, and a watchdog timeout for stalled devices.
- Sits between the CPU datapath and the RAM, UART, LED and future peripherals.

Parameters:
ADDR_WIDTH, 8, CPU address width
DATA_WIDTH, 8, data bus width
IO_BASE, 8'hF0, first IO address; addresses below it map to RAM
NUM_IO, 3, number of peripheral slots (1..8)
REG_BITS, 2, register-select bits per peripheral
TIMEOUT_CYCLES, 16, max ACCESS cycles before error (>=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
cpuReq  in  1  CPU access request, sampled in IDLE only
cpuWriteEnable  in  1  1 = write, 0 = read
cpuAddress  in  ADDR_WIDTH  access address
cpuWriteData  in  DATA_WIDTH  write data
cpuData  out  DATA_WIDTH  registered read data
cpuReady  out  1  one-cycle completion pulse
cpuError  out  1  valid with cpuReady; 1 = unmapped address or timeout
devAddress  out  ADDR_WIDTH  latched address to all slots
devWriteData  out  DATA_WIDTH  latched write data to all slots
regSelect  out  REG_BITS  latched address low bits
ramSelect  out  1  RAM slot active
ramWriteEnable  out  1  RAM write strobe
ramData  in  DATA_WIDTH  RAM read data
ramReady  in  1  RAM done
ioSelect  out  NUM_IO  one-hot peripheral select
ioWriteEnable  out  1  peripheral write strobe, qualified by ioSelect
ioData  in  NUM_IO*DATA_WIDTH  peripheral read data; slot k at bits [k*DW +: DW]
ioReady  in  NUM_IO  per-slot done

Behaviour:
- Clocking and reset: single clock clk; reset is synchronous and active-high.
- On reset, the next edge forces:
  - state to IDLE;
  - all outputs to 0, including cpuData, selects, strobes, cpuReady and cpuError;
  - the timeout counter to 0.
  - Reset during ACCESS drops all selects at that edge; no response is issued.
- Address decode:
  - Address < IO_BASE: RAM.
  - Otherwise off = Address - IO_BASE and slot = off >> REG_BITS.
  - slot < NUM_IO selects ioSelect[slot]; slot >= NUM_IO is unmapped.
  - regSelect = Address[REG_BITS-1:0].
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If cpuReq=1, latch address, write data and write enable into devAddress, devWriteData and an internal we.
  - If mapped, go to ACCESS.
  - If unmapped, go to RESP with error=1 and readback = all ones.
  - cpuReq is ignored in ACCESS and RESP.
- ACCESS:
  - Exactly one select is high: ramSelect or one ioSelect bit.
  - ramWriteEnable = we & ramSelect; ioWriteEnable = we & |ioSelect.
  - Strobes stay high every ACCESS cycle until the selected ready.
  - When the selected slot's ready=1: capture its read data into cpuData (reads only; writes leave cpuData unchanged), then go to RESP with error=0.
  - Ready from unselected slots is ignored.
  - The counter increments each ACCESS cycle. If it reaches TIMEOUT_CYCLES with no ready, go to RESP with error=1; cpuData = all ones for reads.
- RESP:
  - cpuReady=1 and cpuError valid for exactly one cycle; selects are low.
  - Return to IDLE and clear the counter.
  - cpuError returns to 0 in IDLE.
- Latency:
  - Zero-wait device: cpuReq sampled at edge 0, ACCESS at cycle 1, cpuReady high at cycle 2.
  - Each wait cycle adds 1 cycle.
  - Unmapped access: cpuReady high at cycle 1.
- cpuData holds the last read value between accesses.
- Ready and timeout in the same cycle: ready wins and no error is reported.
- Back-to-back accesses: a new cpuReq is accepted in the IDLE cycle directly after RESP.

Test Plan:
- Reset, then read 8'h10 with ramData=8'hA5 and ramReady tied 1 -> ramSelect high exactly 1 cycle; cpuReady at cycle 2; cpuData=8'hA5; cpuError=0.
- Write 8'h3C to 8'hF5 -> ioSelect=3'b010, regSelect=2'b01, ioWriteEnable=1 until ioReady[1]. Hold ioReady[1] low 3 cycles -> cpuReady at cycle 5; cpuData unchanged.
- Read 8'hFD (slot 3, unmapped with NUM_IO=3) -> no select asserted; cpuReady and cpuError at cycle 1; cpuData=8'hFF.
- Read 8'hF8 with ioReady[2] held 0 -> exactly 16 ACCESS cycles, then cpuReady=1, cpuError=1, cpuData=8'hFF.
- Assert ioReady[0] while accessing slot 2 -> ignored, access still waits for ioReady[2]. Assert reset mid-ACCESS -> next edge: all selects 0, no cpuReady, state IDLE.
- Two back-to-back reads, RAM 8'h00 then UART 8'hF0, with cpuReq held high -> second access enters ACCESS one cycle after the first RESP; both return correct data.

Source files
------------

// File: rtl/mmio_bus_fabric.sv
// CPU-side request/ready port fanned out to one RAM slot and NUM_IO register-mapped peripherals,
// with device wait states, registered read data, unmapped-address errors and a stall watchdog.
module mmio_bus_fabric #(
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    DATA_WIDTH     = 8,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE        = 8'hF0,
  parameter int                    NUM_IO         = 3,
  parameter int                    REG_BITS       = 2,
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cpuReq,
  input  logic                         cpuWriteEnable,
  input  logic [ADDR_WIDTH-1:0]        cpuAddress,
  input  logic [DATA_WIDTH-1:0]        cpuWriteData,
  output logic [DATA_WIDTH-1:0]        cpuData,
  output logic                         cpuReady,
  output logic                         cpuError,
  output logic [ADDR_WIDTH-1:0]        devAddress,
  output logic [DATA_WIDTH-1:0]        devWriteData,
  output logic [REG_BITS-1:0]          regSelect,
  output logic                         ramSelect,
  output logic                         ramWriteEnable,
  input  logic [DATA_WIDTH-1:0]        ramData,
  input  logic                         ramReady,
  output logic [NUM_IO-1:0]            ioSelect,
  output logic                         ioWriteEnable,
  input  logic [NUM_IO*DATA_WIDTH-1:0] ioData,
  input  logic [NUM_IO-1:0]            ioReady
);

  localparam int                    CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] NUM_IO_A = ADDR_WIDTH'(NUM_IO);
  localparam logic [CW-1:0]         CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t                  r_state, w_state_next;
  logic [ADDR_WIDTH-1:0]   r_addr, w_addr_next;
  logic [DATA_WIDTH-1:0]   r_wdata, w_wdata_next;
  logic [REG_BITS-1:0]     r_reg_sel, w_reg_sel_next;
  logic                    r_we, w_we_next;
  logic                    r_ram_sel, w_ram_sel_next;
  logic [NUM_IO-1:0]       r_io_sel, w_io_sel_next;
  logic [DATA_WIDTH-1:0]   r_data, w_data_next;
  logic                    r_ready, w_ready_next;
  logic                    r_error, w_error_next;
  logic [CW-1:0]           r_cnt, w_cnt_next;

  // Request decode, evaluated combinationally on the live CPU address
  logic                    w_is_ram;
  logic [ADDR_WIDTH-1:0]   w_off;
  logic [ADDR_WIDTH-1:0]   w_slot;
  logic                    w_io_hit;
  logic [NUM_IO-1:0]       w_io_dec;

  assign w_is_ram = (cpuAddress < IO_BASE);
  assign w_off    = cpuAddress - IO_BASE;
  assign w_slot   = w_off >> REG_BITS;
  assign w_io_hit = !w_is_ram && (w_slot < NUM_IO_A);

  logic [DATA_WIDTH-1:0]   w_slot_rdata [NUM_IO];
  logic [DATA_WIDTH-1:0]   w_io_rdata;
  logic [DATA_WIDTH-1:0]   w_sel_rdata;
  logic                    w_sel_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IO; gi++) begin : g_slot
      assign w_io_dec[gi]     = w_io_hit && (w_slot == ADDR_WIDTH'(gi));
      assign w_slot_rdata[gi] = r_io_sel[gi] ? ioData[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  endgenerate

  always_comb begin
    w_io_rdata = '0;
    for (int k = 0; k < NUM_IO; k++) begin
      w_io_rdata = w_io_rdata | w_slot_rdata[k];
    end
  end

  // Only the selected slot's ready and data matter; the others are masked out
  assign w_sel_rdata = r_ram_sel ? ramData : w_io_rdata;
  assign w_sel_ready = (r_ram_sel & ramReady) | (|(r_io_sel & ioReady));

  always_comb begin
    w_state_next   = r_state;
    w_addr_next    = r_addr;
    w_wdata_next   = r_wdata;
    w_reg_sel_next = r_reg_sel;
    w_we_next      = r_we;
    w_ram_sel_next = r_ram_sel;
    w_io_sel_next  = r_io_sel;
    w_data_next    = r_data;
    w_ready_next   = 1'b0;
    w_error_next   = 1'b0;
    w_cnt_next     = r_cnt;

    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (cpuReq) begin
          w_addr_next    = cpuAddress;
          w_wdata_next   = cpuWriteData;
          w_reg_sel_next = cpuAddress[REG_BITS-1:0];
          w_we_next      = cpuWriteEnable;
          if (w_is_ram || w_io_hit) begin
            w_ram_sel_next = w_is_ram;
            w_io_sel_next  = w_io_dec;
            w_state_next   = S_ACCESS;
          end else begin
            w_ready_next = 1'b1;
            w_error_next = 1'b1;
            if (!cpuWriteEnable) w_data_next = '1;
            w_state_next = S_RESP;
          end
        end
      end

      S_ACCESS: begin
        // Ready is checked before the watchdog so a last-cycle ready still succeeds
        if (w_sel_ready) begin
          if (!r_we) w_data_next = w_sel_rdata;
          w_ram_sel_next = 1'b0;
          w_io_sel_next  = '0;
          w_ready_next   = 1'b1;
          w_state_next   = S_RESP;
        end else if (r_cnt == CNT_LAST) begin
          if (!r_we) w_data_next = '1;
          w_ram_sel_next = 1'b0;
          w_io_sel_next  = '0;
          w_ready_next   = 1'b1;
          w_error_next   = 1'b1;
          w_state_next   = S_RESP;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      S_RESP: begin
        w_cnt_next   = '0;
        w_state_next = S_IDLE;
      end

      default: begin
        w_ram_sel_next = 1'b0;
        w_io_sel_next  = '0;
        w_cnt_next     = '0;
        w_state_next   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_reg_sel <= '0;
      r_we      <= 1'b0;
      r_ram_sel <= 1'b0;
      r_io_sel  <= '0;
      r_data    <= '0;
      r_ready   <= 1'b0;
      r_error   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_addr    <= w_addr_next;
      r_wdata   <= w_wdata_next;
      r_reg_sel <= w_reg_sel_next;
      r_we      <= w_we_next;
      r_ram_sel <= w_ram_sel_next;
      r_io_sel  <= w_io_sel_next;
      r_data    <= w_data_next;
      r_ready   <= w_ready_next;
      r_error   <= w_error_next;
      r_cnt     <= w_cnt_next;
    end
  end

  assign cpuData        = r_data;
  assign cpuReady       = r_ready;
  assign cpuError       = r_error;
  assign devAddress     = r_addr;
  assign devWriteData   = r_wdata;
  assign regSelect      = r_reg_sel;
  assign ramSelect      = r_ram_sel;
  assign ioSelect       = r_io_sel;
  assign ramWriteEnable = r_we & r_ram_sel;
  assign ioWriteEnable  = r_we & (|r_io_sel);

endmodule

// File: tb/tb_mmio_bus_fabric.sv
// Directed and randomized bench for mmio_bus_fabric: transaction-level reference model of the
// memory map, device memories driven by the bench, per-transaction latency/data/error checks.
module tb_mmio_bus_fabric;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpuReq;
  logic        cpuWriteEnable;
  logic [7:0]  cpuAddress;
  logic [7:0]  cpuWriteData;
  logic [7:0]  cpuData;
  logic        cpuReady;
  logic        cpuError;
  logic [7:0]  devAddress;
  logic [7:0]  devWriteData;
  logic [1:0]  regSelect;
  logic        ramSelect;
  logic        ramWriteEnable;
  logic [7:0]  ramData;
  logic        ramReady;
  logic [2:0]  ioSelect;
  logic        ioWriteEnable;
  logic [23:0] ioData;
  logic [2:0]  ioReady;

  int n_checks = 0;
  int n_fails  = 0;

  // Device contents (what the slots hold) and the reference model's view of them
  logic [7:0] dev_mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] dev_io  [12];
  logic [7:0] ref_io  [12];
  logic [7:0] exp_data;

  mmio_bus_fabric dut (
    .clk            (clk),
    .reset          (reset),
    .cpuReq         (cpuReq),
    .cpuWriteEnable (cpuWriteEnable),
    .cpuAddress     (cpuAddress),
    .cpuWriteData   (cpuWriteData),
    .cpuData        (cpuData),
    .cpuReady       (cpuReady),
    .cpuError       (cpuError),
    .devAddress     (devAddress),
    .devWriteData   (devWriteData),
    .regSelect      (regSelect),
    .ramSelect      (ramSelect),
    .ramWriteEnable (ramWriteEnable),
    .ramData        (ramData),
    .ramReady       (ramReady),
    .ioSelect       (ioSelect),
    .ioWriteEnable  (ioWriteEnable),
    .ioData         (ioData),
    .ioReady        (ioReady)
  );

  always #5 clk = ~clk;

  always_comb begin
    ramData = dev_mem[devAddress];
    ioData  = '0;
    for (int k = 0; k < 3; k++) begin
      ioData[k*8 +: 8] = dev_io[k*4 + int'(regSelect)];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One CPU transaction; waits = ACCESS cycles with ready low before the device answers
  task automatic do_access(input logic [7:0] addr, input logic we, input logic [7:0] wdata,
                           input int waits, input bit noise);
    bit         is_ram, mapped, ok, done, rdy, wr_ram, wr_io;
    int         slot, c, bad, exp_lat, idx;
    logic [2:0] exp_io;
    logic [7:0] exp_rd, wr_addr, wr_val;
    logic [1:0] wr_reg;
    logic [2:0] wr_sel;

    is_ram  = (addr < 8'hF0);
    slot    = is_ram ? 0 : (int'(addr) - 240) / 4;
    mapped  = is_ram || (slot < 3);
    ok      = mapped && (waits < 16);
    exp_io  = (!is_ram && mapped) ? 3'(1 << slot) : 3'b000;
    exp_lat = !mapped ? 1 : (waits < 16 ? waits + 2 : 17);
    idx     = slot * 4 + int'(addr[1:0]);
    exp_rd  = is_ram ? ref_mem[addr] : (mapped ? ref_io[idx] : 8'hFF);

    @(negedge clk);
    cpuReq = 1'b1; cpuWriteEnable = we; cpuAddress = addr; cpuWriteData = wdata;
    ramReady = 1'b0; ioReady = 3'b000;
    @(posedge clk); #1;
    // Scramble the CPU-side inputs so any failure to latch shows up
    cpuReq = 1'b0; cpuWriteEnable = 1'($urandom); cpuAddress = 8'($urandom); cpuWriteData = 8'($urandom);
    c = 1; bad = 0; done = 1'b0;
    while (!done && c <= 40) begin
      if (cpuReady) begin
        done = 1'b1;
      end else begin
        if (ramSelect !== is_ram || ioSelect !== exp_io || devAddress !== addr ||
            regSelect !== addr[1:0] || devWriteData !== wdata ||
            ramWriteEnable !== (we && is_ram) || ioWriteEnable !== (we && !is_ram) ||
            cpuError !== 1'b0) bad++;
        rdy = (c - 1 >= waits);
        ramReady = is_ram ? rdy : (noise ? 1'($urandom) : 1'b0);
        for (int k = 0; k < 3; k++) begin
          ioReady[k] = (!is_ram && k == slot) ? rdy : (noise ? 1'($urandom) : 1'b0);
        end
        wr_ram = ramSelect && ramWriteEnable && ramReady;
        wr_io  = ((ioSelect & ioReady) != 3'b000) && ioWriteEnable;
        wr_addr = devAddress; wr_val = devWriteData; wr_reg = regSelect; wr_sel = ioSelect;
        @(posedge clk); #1;
        if (wr_ram) dev_mem[wr_addr] = wr_val;
        if (wr_io) begin
          for (int k = 0; k < 3; k++) if (wr_sel[k]) dev_io[k*4 + int'(wr_reg)] = wr_val;
        end
        c++;
      end
    end
    ramReady = 1'b0; ioReady = 3'b000;

    if (!ok && mapped) begin
      // Watchdog expiry: reads return all ones, writes leave cpuData alone
      if (!we) exp_data = 8'hFF;
    end else if (!mapped) begin
      if (!we) exp_data = 8'hFF;
    end else if (we) begin
      if (is_ram) ref_mem[addr] = wdata; else ref_io[idx] = wdata;
    end else begin
      exp_data = exp_rd;
    end

    $display("txn addr=%02h we=%0d wdata=%02h waits=%0d -> lat=%0d err=%0d data=%02h",
             addr, we, wdata, waits, c, cpuError, cpuData);
    chk("response_seen", done, 1);
    chk("latency", c, exp_lat);
    chk("access_cycles_ok", bad, 0);
    chk("cpuError", cpuError, !ok);
    chk("cpuData", cpuData, exp_data);
    chk("selects_low_in_resp", {ramSelect, ioSelect}, 0);
    @(posedge clk); #1;
    chk("ready_one_cycle", {cpuReady, cpuError}, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] a, d;
    int cat, w;
    bit wr;

    for (int i = 0; i < 256; i++) begin
      dev_mem[i] = 8'($urandom);
      ref_mem[i] = dev_mem[i];
    end
    for (int i = 0; i < 12; i++) begin
      dev_io[i] = 8'($urandom);
      ref_io[i] = dev_io[i];
    end
    dev_mem[8'h10] = 8'hA5; ref_mem[8'h10] = 8'hA5;
    dev_mem[8'h00] = 8'h5A; ref_mem[8'h00] = 8'h5A;
    dev_io[0]      = 8'hC3; ref_io[0]      = 8'hC3;

    reset = 1'b1; cpuReq = 1'b0; cpuWriteEnable = 1'b0; cpuAddress = '0; cpuWriteData = '0;
    ramReady = 1'b0; ioReady = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {cpuData, cpuReady, cpuError, ramSelect, ramWriteEnable, ioSelect, ioWriteEnable,
                          devAddress, devWriteData, regSelect}, 0);
    @(negedge clk); reset = 1'b0;
    exp_data = 8'h00;

    // Directed scenarios
    do_access(8'h10, 1'b0, 8'h00, 0, 1'b0);
    do_access(8'hF5, 1'b1, 8'h3C, 3, 1'b0);
    do_access(8'hF5, 1'b0, 8'h00, 0, 1'b0);
    do_access(8'hFD, 1'b0, 8'h00, 0, 1'b0);
    do_access(8'hF8, 1'b0, 8'h00, 99, 1'b0);
    do_access(8'hF9, 1'b0, 8'h00, 15, 1'b0);
    do_access(8'h20, 1'b1, 8'h77, 16, 1'b0);

    // Spurious ready on slot 0 while slot 2 is waiting
    @(negedge clk);
    cpuReq = 1'b1; cpuWriteEnable = 1'b0; cpuAddress = 8'hF8; ioReady = 3'b001; ramReady = 1'b1;
    @(posedge clk); #1;
    cpuReq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("foreign_ready_ignored", {cpuReady, ioSelect}, {1'b0, 3'b100});
    // Reset in the middle of ACCESS drops the select without a response
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("reset_mid_access", {cpuReady, cpuError, ramSelect, ioSelect, cpuData}, 0);
    @(negedge clk); reset = 1'b0; ioReady = 3'b000; ramReady = 1'b0;
    @(posedge clk); #1;
    chk("no_resp_after_reset", {cpuReady, ioSelect}, 0);
    exp_data = 8'h00;

    // Back-to-back reads with cpuReq held high throughout
    @(negedge clk);
    cpuReq = 1'b1; cpuWriteEnable = 1'b0; cpuAddress = 8'h00; ramReady = 1'b1; ioReady = 3'b001;
    @(posedge clk); #1;
    chk("b2b_first_access", {ramSelect, ioSelect}, 4'b1000);
    @(posedge clk); #1;
    chk("b2b_first_resp", {cpuReady, cpuError, cpuData}, {2'b10, ref_mem[0]});
    cpuAddress = 8'hF0;
    @(posedge clk); #1;
    chk("b2b_idle_gap", {cpuReady, ramSelect, ioSelect}, 0);
    @(posedge clk); #1;
    chk("b2b_second_access", {ramSelect, ioSelect}, 4'b0001);
    cpuReq = 1'b0;
    @(posedge clk); #1;
    chk("b2b_second_resp", {cpuReady, cpuError, cpuData}, {2'b10, ref_io[0]});
    exp_data = ref_io[0];
    ramReady = 1'b0; ioReady = 3'b000;
    @(posedge clk); #1;

    // Randomized traffic over RAM, all IO slots and the unmapped hole
    for (int t = 0; t < 60; t++) begin
      cat = $urandom_range(0, 9);
      if (cat < 4)      a = 8'($urandom_range(0, 239));
      else if (cat < 8) a = 8'(8'hF0 + $urandom_range(0, 11));
      else              a = 8'(8'hFC + $urandom_range(0, 3));
      wr = (cat < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
      d  = 8'($urandom);
      w  = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 4) : $urandom_range(14, 17);
      do_access(a, wr, d, w, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
